// File: rtl/rd_deserializer.sv
// Two-channel RD serial receiver: 13-bit frames (12 data MSB-first + odd parity) -> 24-bit word writes.
// Latency: WR_EN/WR_ADDR/WR_DATA valid the cycle after the parity bit is sampled.
// Backpressure: none; the sink must accept one write every 13 cycles. Optional RD_PARITY_CHECK_EN enables parity counting.
module rd_deserializer #(
    parameter int NWORDS = 2048
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        XFR_IN,
    input  logic        SERIAL_IN0,
    input  logic        SERIAL_IN1,
    output logic        WR_EN,
    output logic [10:0] WR_ADDR,
    output logic [23:0] WR_DATA,
    output logic [11:0] PERR_CNT0,
    output logic [11:0] PERR_CNT1,
    output logic        SHORT_ERR,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  bit_cnt;
    logic [10:0] word_idx;
    logic [11:0] sh0;
    logic [11:0] sh1;

    // Decoded per-cycle actions from the controller
    logic        start;      // IDLE->RECV, first data bit sampled on this edge
    logic        take_bit;   // shift one data bit into both channels
    logic        frame_end;  // parity bit sampled, write issued next cycle
    logic        set_short;  // transfer ended early
    logic        last_word;

    assign last_word = (word_idx == 11'(NWORDS - 1));
    assign BUSY      = (state == S_RECV);
    assign DONE      = (state == S_DONE);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and action decode; ENABLE low always wins, XFR_IN low ends the transfer
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        take_bit  = 1'b0;
        frame_end = 1'b0;
        set_short = 1'b0;
        case (state)
            S_IDLE: begin
                if (ENABLE && XFR_IN) begin
                    state_nxt = S_RECV;
                    start     = 1'b1;
                    take_bit  = 1'b1;
                end
            end
            S_RECV: begin
                if (!ENABLE) begin
                    state_nxt = S_IDLE;
                end else if (bit_cnt == 4'd12) begin
                    // A parity bit arriving with XFR_IN falling still completes its word
                    frame_end = 1'b1;
                    if (last_word) begin
                        state_nxt = S_DONE;
                    end else if (!XFR_IN) begin
                        state_nxt = S_DONE;
                        set_short = 1'b1;
                    end
                end else if (!XFR_IN) begin
                    state_nxt = S_DONE;
                    set_short = 1'b1;
                end else begin
                    take_bit = 1'b1;
                end
            end
            S_DONE: begin
                if (!ENABLE) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit/word counters, shift registers, write port and short-transfer flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt   <= 4'd0;
            word_idx  <= 11'd0;
            sh0       <= 12'd0;
            sh1       <= 12'd0;
            WR_EN     <= 1'b0;
            WR_ADDR   <= 11'd0;
            WR_DATA   <= 24'd0;
            SHORT_ERR <= 1'b0;
        end else begin
            WR_EN <= frame_end;
            if (take_bit) begin
                sh0     <= {sh0[10:0], SERIAL_IN0};
                sh1     <= {sh1[10:0], SERIAL_IN1};
                bit_cnt <= start ? 4'd1 : bit_cnt + 4'd1;
            end
            if (start) begin
                word_idx  <= 11'd0;
                SHORT_ERR <= 1'b0;
            end
            if (frame_end) begin
                WR_ADDR  <= word_idx;
                WR_DATA  <= {sh1, sh0};
                word_idx <= word_idx + 11'd1;
                bit_cnt  <= 4'd0;
            end
            if (set_short) SHORT_ERR <= 1'b1;
        end
    end

`ifdef RD_PARITY_CHECK_EN
    logic par_err0;
    logic par_err1;

    // Odd parity: data bits plus parity bit must XOR to 1
    assign par_err0 = ~(^{sh0, SERIAL_IN0});
    assign par_err1 = ~(^{sh1, SERIAL_IN1});

    // Saturating parity-error counters, cleared at the start of each transfer
    always_ff @(posedge CLK) begin
        if (RST || start) begin
            PERR_CNT0 <= 12'd0;
            PERR_CNT1 <= 12'd0;
        end else if (frame_end) begin
            if (par_err0 && PERR_CNT0 != 12'hFFF) PERR_CNT0 <= PERR_CNT0 + 12'd1;
            if (par_err1 && PERR_CNT1 != 12'hFFF) PERR_CNT1 <= PERR_CNT1 + 12'd1;
        end
    end
`else
    // Parity bit is still consumed as the 13th frame bit but never checked
    assign PERR_CNT0 = 12'd0;
    assign PERR_CNT1 = 12'd0;
`endif

endmodule

// File: tb/tb_rd_deserializer.sv
// Scoreboard bench for rd_deserializer: sender model drives frames, monitor pops expected writes.
// Covers reset, disabled, full, parity fault, short, coincident drop, reset mid-word and rearm.
// Serial/XFR inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rd_deserializer;

    localparam int NW = 2048;
`ifdef RD_PARITY_CHECK_EN
    localparam int EXP_PERR1 = 2;
`else
    localparam int EXP_PERR1 = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic        XFR_IN = 1'b0;
    logic        SERIAL_IN0 = 1'b0;
    logic        SERIAL_IN1 = 1'b0;
    logic        WR_EN;
    logic [10:0] WR_ADDR;
    logic [23:0] WR_DATA;
    logic [11:0] PERR_CNT0;
    logic [11:0] PERR_CNT1;
    logic        SHORT_ERR;
    logic        BUSY;
    logic        DONE;

    rd_deserializer #(.NWORDS(NW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENABLE     (ENABLE),
        .XFR_IN     (XFR_IN),
        .SERIAL_IN0 (SERIAL_IN0),
        .SERIAL_IN1 (SERIAL_IN1),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .PERR_CNT0  (PERR_CNT0),
        .PERR_CNT1  (PERR_CNT1),
        .SHORT_ERR  (SHORT_ERR),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [10:0] addr;
        logic [23:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_err  = 0;
    int  n_chk  = 0;
    int  wr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word
    always @(negedge CLK) begin
        if (WR_EN === 1'b1) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(WR_ADDR), 32'(e.addr));
                chk("wr_data", 32'(WR_DATA), 32'(e.data));
            end
        end
    end

    // Drive one frame (or its first nbits); optionally drop XFR_IN together with the parity bit
    task automatic send_word(input logic [11:0] d0, input logic [11:0] d1, input bit flip1,
                             input int nbits, input bit drop_at_par, input bit expect_wr,
                             input logic [10:0] addr);
        if (expect_wr) sb.push_back('{addr: addr, data: {d1, d0}});
        for (int b = 0; b < nbits; b++) begin
            @(negedge CLK);
            XFR_IN = !(drop_at_par && b == 12);
            if (b < 12) begin
                SERIAL_IN0 = d0[11 - b];
                SERIAL_IN1 = d1[11 - b];
            end else begin
                SERIAL_IN0 = ~^d0;
                SERIAL_IN1 = (~^d1) ^ flip1;
            end
        end
    endtask

    task automatic end_xfer();
        @(negedge CLK);
        XFR_IN = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && DONE !== 1'b1; i++) @(negedge CLK);
        chk("done_reached", 32'(DONE), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic rearm();
        @(negedge CLK);
        ENABLE = 1'b0;
        @(negedge CLK);
        ENABLE = 1'b1;
        chk("rearm_done_low", 32'(DONE), 32'd0);
        chk("rearm_busy_low", 32'(BUSY), 32'd0);
    endtask

    task automatic send_words(input int count, input bit faults);
        for (int n = 0; n < count; n++) begin
            logic [11:0] d0;
            logic [11:0] d1;
            d0 = 12'(n);
            d1 = 12'(0 - n);
            send_word(d0, d1, faults && (n == 5 || n == 9), 13, 1'b0, 1'b1, 11'(n));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_en"},   32'(WR_EN), 32'd0);
        chk({tag, "_wr_addr"}, 32'(WR_ADDR), 32'd0);
        chk({tag, "_wr_data"}, 32'(WR_DATA), 32'd0);
        chk({tag, "_perr0"},   32'(PERR_CNT0), 32'd0);
        chk({tag, "_perr1"},   32'(PERR_CNT1), 32'd0);
        chk({tag, "_short"},   32'(SHORT_ERR), 32'd0);
        chk({tag, "_busy"},    32'(BUSY), 32'd0);
        chk({tag, "_done"},    32'(DONE), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        repeat (2) @(negedge CLK);
        chk_reset_vals("reset");
        RST = 1'b0;

        // Disabled: XFR_IN toggles, nothing may start
        base = wr_cnt;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            XFR_IN     = ~XFR_IN;
            SERIAL_IN0 = i[0];
            chk("disabled_busy", 32'(BUSY), 32'd0);
        end
        XFR_IN = 1'b0;
        @(negedge CLK);
        chk("disabled_wr_count", 32'(wr_cnt - base), 32'd0);

        // Full clean transfer
        ENABLE = 1'b1;
        base = wr_cnt;
        send_words(NW, 1'b0);
        end_xfer();
        wait_done();
        chk("full_wr_count", 32'(wr_cnt - base), 32'(NW));
        chk("full_short", 32'(SHORT_ERR), 32'd0);
        chk("full_perr0", 32'(PERR_CNT0), 32'd0);
        chk("full_perr1", 32'(PERR_CNT1), 32'd0);

        // Full transfer with bad ch1 parity on words 5 and 9
        rearm();
        base = wr_cnt;
        send_words(NW, 1'b1);
        end_xfer();
        wait_done();
        chk("fault_wr_count", 32'(wr_cnt - base), 32'(NW));
        chk("fault_perr0", 32'(PERR_CNT0), 32'd0);
        chk("fault_perr1", 32'(PERR_CNT1), 32'(EXP_PERR1));

        // Short transfer: 100 words plus 6 bits
        rearm();
        chk("rearm_perr1_held", 32'(PERR_CNT1), 32'(EXP_PERR1));
        base = wr_cnt;
        send_words(100, 1'b0);
        send_word(12'hABC, 12'h123, 1'b0, 6, 1'b0, 1'b0, 11'd0);
        end_xfer();
        wait_done();
        chk("short_wr_count", 32'(wr_cnt - base), 32'd100);
        chk("short_flag", 32'(SHORT_ERR), 32'd1);

        // Rearm: flags clear on start; XFR_IN falls with the third parity bit
        rearm();
        base = wr_cnt;
        send_word(12'h5A5, 12'h0F0, 1'b0, 13, 1'b0, 1'b1, 11'd0);
        chk("rearm_short_cleared", 32'(SHORT_ERR), 32'd0);
        chk("rearm_busy", 32'(BUSY), 32'd1);
        send_word(12'hFFF, 12'h800, 1'b0, 13, 1'b0, 1'b1, 11'd1);
        send_word(12'h001, 12'h7FE, 1'b0, 13, 1'b1, 1'b1, 11'd2);
        repeat (3) @(negedge CLK);
        wait_done();
        chk("coincide_wr_count", 32'(wr_cnt - base), 32'd3);
        chk("coincide_short", 32'(SHORT_ERR), 32'd1);

        // Reset during word 40, then a fresh transfer restarts at address 0
        rearm();
        send_words(40, 1'b0);
        send_word(12'h3C3, 12'hC3C, 1'b0, 7, 1'b0, 1'b0, 11'd0);
        @(negedge CLK);
        RST    = 1'b1;
        XFR_IN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        chk_reset_vals("midreset");
        base = wr_cnt;
        repeat (20) @(negedge CLK);
        chk("midreset_no_wr", 32'(wr_cnt - base), 32'd0);
        chk("midreset_idle", 32'(BUSY), 32'd0);
        send_word(12'h111, 12'h222, 1'b0, 13, 1'b0, 1'b1, 11'd0);
        send_word(12'h333, 12'h444, 1'b0, 13, 1'b0, 1'b1, 11'd1);
        end_xfer();
        wait_done();
        chk("restart_wr_count", 32'(wr_cnt - base), 32'd2);
        chk("restart_short", 32'(SHORT_ERR), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
